// File: rtl/count_sequencer.sv
// Start/run/done count sequencer with pause, abort and async active-low reset.
// Define COUNT_SEQUENCER_AUTO_RELOAD_EN for free-running reload at terminal count.
module count_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_req,
  input  logic [WIDTH-1:0] term_cnt,
  input  logic             pause,
  input  logic             abort,
  output logic             start_ack,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] tc_q;
  logic [WIDTH-1:0] cnt_q;
  logic             ack_q;
  logic             busy_q;
  logic             done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tc_q    <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_req && !abort) begin
            tc_q    <= term_cnt;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            ack_q   <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          // abort outranks pause and the terminal check
          if (abort) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (!pause) begin
            if (cnt_q != tc_q) begin
              cnt_q <= cnt_q + 1'b1;
            end else begin
              done_q <= 1'b1;
`ifdef COUNT_SEQUENCER_AUTO_RELOAD_EN
              cnt_q  <= '0;
`else
              busy_q  <= 1'b0;
              state_q <= DONE;
`endif
            end
          end
        end
        DONE: begin
          if (abort) cnt_q <= '0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign start_ack = ack_q;
  assign count     = cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
